// File: rtl/mixcolumns_engine_if.sv
// Block handshake bundle for mixcolumns_engine: input block channel, result
// channel, clock enable and busy status.
interface mixcolumns_engine_if;
    logic         en;
    logic [127:0] din;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] dout;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output en, din, mode, in_valid, out_ready,
        input  in_ready, dout, out_valid, busy
    );

    modport slave (
        input  en, din, mode, in_valid, out_ready,
        output in_ready, dout, out_valid, busy
    );
endinterface

// File: rtl/mixcolumns_engine.sv
// AES (Inv)MixColumns engine: accepts a 128-bit state, transforms LANES
// columns per enabled cycle and holds the result until consumed.
module mixcolumns_engine #(
    parameter int LANES = 1
) (
    input  logic               clock,
    input  logic               reset,
    mixcolumns_engine_if.slave bus
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("mixcolumns_engine: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [2:0]              col_r;
    logic [0:3][31:0]        din_r;
    logic [0:3][31:0]        dout_r;
    logic                    mode_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic [LANES-1:0][31:0]  mix_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients never exceed 4 bits, so three doublings cover every term.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [3:0]  k [4];
        logic [7:0]  acc;
        logic [31:0] res;
        if (inv) begin
            k = '{4'he, 4'hb, 4'hd, 4'h9};
        end else begin
            k = '{4'h2, 4'h3, 4'h1, 4'h1};
        end
        res = 32'h0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ gmul(col[31-8*j -: 8], k[2'(j - r)]);
            end
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    // Transform the LANES columns addressed by the column counter.
    always_comb begin
        mix_s = '0;
        for (int l = 0; l < LANES; l++) begin
            mix_s[l] = mix_col(din_r[col_r[1:0] + 2'(l)], mode_r);
        end
    end

    // Control FSM with registered handshake outputs and result columns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            col_r       <= 3'd0;
            din_r       <= '0;
            dout_r      <= '0;
            mode_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (bus.en) begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        din_r      <= bus.din;
                        mode_r     <= bus.mode;
                        col_r      <= 3'd0;
                        state_r    <= BUSY;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        dout_r[col_r[1:0] + 2'(l)] <= mix_s[l];
                    end
                    col_r <= col_r + 3'(LANES);
                    if (col_r + 3'(LANES) == 3'd4) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Consumption returns to IDLE only; a new block waits a cycle.
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    col_r       <= 3'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout      = dout_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mixcolumns_engine.sv
// Scoreboard bench for mixcolumns_engine: LANES=1,2,4 instances share one
// stimulus stream; per-instance monitors check results, latency and holding.
module tb_mixcolumns_engine;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] din = 128'h0;
    bit           rnd = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [3][$];
    logic [2:0]   rdy_s;
    logic [2:0]   ov_s;
    logic [2:0]   bz_s;
    logic [127:0] dout_a [3];

    always #5 clock = ~clock;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: shift-and-add GF(2^8) product and a circulant matrix.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic m);
        logic [7:0]   k [4];
        logic [7:0]   acc;
        logic [127:0] o = 128'h0;
        if (m) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   k = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gm(s[127-32*c-8*j -: 8], k[(j - r + 4) % 4]);
                end
                o[127-32*c-8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : gl
            localparam int L = 1 << g;
            mixcolumns_engine_if ifc();
            assign ifc.en        = en;
            assign ifc.din       = din;
            assign ifc.mode      = mode;
            assign ifc.in_valid  = in_valid;
            assign ifc.out_ready = out_ready;
            assign rdy_s[g]      = ifc.in_ready;
            assign ov_s[g]       = ifc.out_valid;
            assign bz_s[g]       = ifc.busy;
            assign dout_a[g]     = ifc.dout;

            mixcolumns_engine #(.LANES(L)) dut (
                .clock (clock),
                .reset (reset),
                .bus   (ifc.slave)
            );

            bit           active = 1'b0;
            bit           en_p = 1'b0;
            bit           acc_p = 1'b0;
            bit           ov_p = 1'b0;
            bit           cons_p = 1'b0;
            bit           ir_p = 1'b1;
            bit           bz_p = 1'b0;
            int           lat = 0;
            logic [127:0] dout_p = 128'h0;

            // Monitor: compares against the scoreboard and checks hold rules.
            always @(negedge clock) begin
                if (reset) begin
                    active = 1'b0; acc_p = 1'b0; en_p = 1'b0; ov_p = 1'b0;
                    cons_p = 1'b0; ir_p = 1'b1; bz_p = 1'b0; dout_p = 128'h0;
                end else begin
                    if (!en_p)
                        chk(ifc.dout == dout_p && ifc.out_valid == ov_p && ifc.in_ready == ir_p && ifc.busy == bz_p,
                            $sformatf("en_low_hold_L%0d", L), ifc.dout, dout_p);
                    else if (ov_p && !cons_p)
                        chk(ifc.out_valid && ifc.dout == dout_p, $sformatf("done_hold_L%0d", L), ifc.dout, dout_p);
                    else if (ov_p && cons_p)
                        chk(ifc.in_ready && !ifc.out_valid, $sformatf("release_to_idle_L%0d", L),
                            {126'h0, ifc.in_ready, ifc.out_valid}, 128'h2);
                    if (active && en_p) lat++;
                    if (acc_p) begin
                        active = 1'b1;
                        lat = 0;
                    end
                    if (ifc.out_valid && !ov_p) begin
                        if (!active || exp_q[g].size() == 0) begin
                            chk(1'b0, $sformatf("spurious_out_valid_L%0d", L), ifc.dout, 128'h0);
                        end else begin
                            chk(lat == 4 / L, $sformatf("latency_L%0d", L), 128'(lat), 128'(4 / L));
                            chk(ifc.dout == exp_q[g][0], $sformatf("dout_L%0d", L), ifc.dout, exp_q[g][0]);
                            void'(exp_q[g].pop_front());
                            active = 1'b0;
                        end
                    end
                    chk(!(ifc.in_ready && ifc.out_valid) && ifc.busy == !ifc.in_ready,
                        $sformatf("flags_L%0d", L), {125'h0, ifc.in_ready, ifc.out_valid, ifc.busy}, 128'h0);
                    en_p   = en;
                    acc_p  = en && ifc.in_ready && in_valid;
                    ov_p   = ifc.out_valid;
                    cons_p = en && out_ready && ifc.out_valid;
                    ir_p   = ifc.in_ready;
                    bz_p   = ifc.busy;
                    dout_p = ifc.dout;
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rdy_s != 3'b111 && n < 200) begin
            tick();
            n++;
        end
        chk(rdy_s == 3'b111, "ready_timeout", 128'(rdy_s), 128'h7);
    endtask

    task automatic wait_done();
        int n = 0;
        while (ov_s != 3'b111 && n < 50) begin
            tick();
            n++;
        end
        chk(ov_s == 3'b111, "done_timeout", 128'(ov_s), 128'h7);
    endtask

    task automatic send(input logic [127:0] d, input logic m, input logic [127:0] e);
        wait_ready();
        en = 1'b1;
        din = d;
        mode = m;
        in_valid = 1'b1;
        for (int g = 0; g < 3; g++) exp_q[g].push_back(e);
        tick();
        in_valid = 1'b0;
        din = {$urandom, $urandom, $urandom, $urandom};
        mode = $urandom_range(0, 1);
    endtask

    task automatic check_reset_vals(input string name);
        for (int g = 0; g < 3; g++)
            chk(dout_a[g] == 128'h0 && !ov_s[g] && rdy_s[g] && !bz_s[g], name, dout_a[g], 128'h0);
    endtask

    localparam logic [127:0] V28_IN  = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
    localparam logic [127:0] V28_OUT = {32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101};
    localparam logic [127:0] V29_IN  = {32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    localparam logic [127:0] V29_OUT = {32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

    initial begin
        logic [127:0] r;
        logic         m;
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("reset_state");
        reset = 1'b0;
        en = 1'b1;
        tick();

        send(V28_IN, 1'b0, V28_OUT);
        send(V29_IN, 1'b0, V29_OUT);
        send(V29_OUT, 1'b1, V29_IN);

        // Result held while the consumer stalls.
        wait_ready();
        out_ready = 1'b0;
        send(V29_IN, 1'b0, V29_OUT);
        wait_done();
        repeat (10) tick();
        for (int g = 0; g < 3; g++)
            chk(ov_s[g] && !rdy_s[g], "done_wait_flags", {126'h0, ov_s[g], rdy_s[g]}, 128'h2);
        out_ready = 1'b1;
        tick();
        chk(rdy_s == 3'b111, "idle_after_consume", 128'(rdy_s), 128'h7);

        // Clock-enable freeze mid-block.
        send(V28_IN, 1'b0, V28_OUT);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_ready();

        // Asynchronous reset mid-block discards the pending result.
        send(V28_IN, 1'b0, V28_OUT);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        for (int g = 0; g < 3; g++) exp_q[g].delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (6) tick();
        send(V28_IN, 1'b0, V28_OUT);

        rnd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            m = $urandom_range(0, 1);
            send(r, m, ref_mix(r, m));
        end
        rnd = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        wait_ready();
        tick();
        for (int g = 0; g < 3; g++)
            chk(exp_q[g].size() == 0, "queue_drained", 128'(exp_q[g].size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mixcolumns_engine.md
MIXCOLUMNS_ENGINE -- requirements
Module: mixcolumns_engine

Interface
REQ-001 SHALL have parameter LANES, default 1: number of 32-bit columns processed per active cycle; legal values are 1, 2 and 4.
REQ-002 SHALL fail elaboration if LANES is not 1, 2 or 4.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: clock enable; when 0, all internal state and outputs hold.
REQ-006 SHALL have port din, input, 128 bits: AES state; column c is din[127-32c -: 32], row 0 is the MSB byte of each column.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects MixColumns (encrypt), 1 selects InvMixColumns (decrypt).
REQ-008 SHALL have port in_valid, input, 1 bit: din and mode are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the engine can accept a block.
REQ-010 SHALL have port dout, output, 128 bits: transformed state, using the same byte layout as din.
REQ-011 SHALL have port out_valid, output, 1 bit: dout holds a completed result.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts dout.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement three states: IDLE, BUSY and DONE; no transition occurs while en=0.
REQ-015 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE with in_valid=1 and en=1, capture din and mode at that edge, clear the column counter and enter BUSY.
REQ-017 SHALL, in BUSY, transform LANES consecutive columns per enabled cycle, starting at column 0, and advance the column counter by LANES.
REQ-018 SHALL enter DONE on the enabled edge that completes column 3, so that out_valid rises exactly 4/LANES enabled edges after the accept edge: 4 for LANES=1, 2 for LANES=2, 1 for LANES=4.
REQ-019 SHALL, for mode=0, compute each column with matrix rows [02 03 01 01], [01 02 03 01], [01 01 02 03] and [03 01 01 02] over GF(2^8), reduced by the polynomial 0x11B.
REQ-020 SHALL, for mode=1, compute each column with matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B] and [0B 0D 09 0E] over GF(2^8), reduced by 0x11B.
REQ-021 SHALL build GF multiplication combinationally from xtime chains, with no ROM or file initialisation.
REQ-022 SHALL hold dout and out_valid stable in DONE until out_ready=1 on an enabled edge; on that edge it SHALL return to IDLE, and in_ready SHALL rise in the next cycle.
REQ-023 SHALL never accept a new block in the same cycle as a result is consumed (no overlap).
REQ-024 SHALL ignore din, mode and in_valid in BUSY and DONE; the captured mode applies to the whole block.
REQ-025 SHALL update dout columns only as they are computed, so dout remains stable from the DONE entry edge until consumption.

Reset
REQ-026 SHALL, while reset=1 and independent of clock and en, force IDLE, set dout=0, out_valid=0 and busy=0, set in_ready=1 and clear the column counter.
REQ-027 SHALL, on reset asserted in BUSY or DONE, discard the partial or pending result, with no out_valid pulse after reset release.

Verification
REQ-028 SHALL be verified with LANES=1, mode=0: column db135345 (others 01010101) -> dout column 8e4da1bc with others 01010101, out_valid 4 cycles after accept.
REQ-029 SHALL be verified with LANES=4, mode=0: columns f20a225c, c6c6c6c6, d4d4d4d5, 2d26314c -> 9fdc589d, c6c6c6c6, d5d5d7d6, 4d7ebdf8, out_valid 1 cycle after accept.
REQ-030 SHALL be verified with LANES=2, mode=1: the REQ-029 outputs as input -> the REQ-029 inputs, out_valid 2 cycles after accept.
REQ-031 SHALL be verified with out_ready held at 0 for 10 cycles in DONE: dout and out_valid stable and in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-032 SHALL be verified with en=0 for 3 cycles mid-BUSY: state and counter frozen, and latency extended by exactly 3 cycles.
REQ-033 SHALL be verified with reset asserted asynchronously mid-BUSY: dout=0, out_valid=0 and in_ready=1 immediately; after release, a fresh db135345 block completes correctly.
